hit_event_arbiter: RTL and testbench
====================================

# hit_event_arbiter

Serialises the per-frame collision pulses of the four Kong-vs-object collision sources into one event stream for the score/sound/lives logic. Each source's single-hit pulse is latched, rate-limited by a per-source frame cooldown and a per-frame event budget, then granted one at a time over a valid/ready handshake. The block sits between the collision controller and the game-state consumer, in the `clk` domain.

## Interface
- `MAX_PER_FRAME`, default 4: events granted per frame, legal range 1..15.
- `COOLDOWN_FRAMES`, default 2: frames a source is deaf after its event is accepted, legal range 0..15; 0 means no cooldown.
- `clk` in, 1: system clock.
- `reset` in, 1: synchronous, active-high reset.
- `startOfFrame` in, 1: one-cycle pulse per frame.
- `hit_pulse` in, 4: bit i is the single-hit pulse of source i, at most one cycle per frame per bit.
- `ev_ready` in, 1: consumer accepts the event.
- `ev_valid` out, 1: event presented.
- `ev_id` out, 2: source index of the presented event.
- `pending` out, 4: latched, not-yet-granted hits.
- `overrun` out, 4: sticky; bit i set when a hit on source i was lost.

## Operation
- Reset values: `ev_valid`=0, `ev_id`=0, `pending`=0, `overrun`=0. Budget = MAX_PER_FRAME, all cooldowns = 0, RR pointer = 3, state IDLE.
- Input filter: `hit_pulse[i]` with `cooldown[i]`≠0 is dropped silently. Otherwise it sets `pending[i]`. If `pending[i]` is already 1, set `overrun[i]` instead.
- FSM IDLE: if `pending`≠0 and budget≠0, pick winner w. Set `ev_id`=w and `ev_valid`=1, clear `pending[w]`, go to PRESENT.
- FSM PRESENT: `ev_valid` and `ev_id` are held stable until `ev_ready`=1. On the handshake edge:
  - `ev_valid` drops to 0.
  - budget decrements.
  - `cooldown[w]` loads COOLDOWN_FRAMES.
  - RR pointer becomes w.
  - return to IDLE.
- Budget reloads to MAX_PER_FRAME on `startOfFrame`. At budget 0, pending hits are held for the next frame, not dropped.
- Each nonzero cooldown decrements on `startOfFrame`. Saturation is not needed because the counter never goes below 0.
- Simultaneous events:
  - `startOfFrame` with handshake: budget reload wins, so budget = MAX_PER_FRAME.
  - cooldown load with `startOfFrame` on the same source: the load wins.
  - grant-clear of `pending[w]` with a new accepted hit on w: the set wins and `overrun` is not set.
  - hits arriving during PRESENT are latched normally.
- Reset asserted mid-handshake: `ev_valid` drops at the next edge regardless of `ev_ready`, and the event is lost.
- `overrun` is cleared only by `reset`.

## Timing
- Hit pulse in cycle T sets `pending` at edge T+1. With the FSM in IDLE and budget available, `ev_valid`=1 is seen in cycle T+2.
- Handshake completes on an edge where `ev_valid`&&`ev_ready`. The earliest next `ev_valid` is 2 cycles later (one IDLE cycle in between).
- Maximum throughput is one event per 2 cycles. With `ev_ready` tied high, `ev_valid` is a 1-cycle pulse.
- All outputs are registered. No combinational path exists from `ev_ready` to `ev_valid`.

## Configuration
- `HIT_ARB_ROUND_ROBIN_EN` defined: the winner is the first pending source searching from RR pointer+1 upward, modulo 4.
- Macro undefined: fixed priority, where the lowest pending index wins. The RR pointer is not implemented.
- All other behaviour is identical in both builds.

## Test plan
- Reset, then `hit_pulse`=4'b0100 in cycle 10 with `ev_ready`=1 -> `pending`=4'b0100 in cycle 11. `ev_valid`=1 and `ev_id`=2 in cycle 12, for one cycle. Budget drops to 3.
- `hit_pulse`=4'b1011 in one cycle with `ev_ready`=1 -> RR build: ids 0,1,3 at 2-cycle spacing. Fixed build: also 0,1,3. Then a second 4'b1011 in the next frame -> RR build repeats 0,1,3 (pointer wraps from 3).
- `ev_ready`=0 for 20 cycles while presenting id 1 -> `ev_valid` and `ev_id` stay constant. A hit on source 1 during the wait latches `pending[1]`. A second hit on source 1 sets `overrun[1]`.
- MAX_PER_FRAME=2 with hits on all 4 sources -> exactly 2 events this frame and `pending` holds 2 bits. After `startOfFrame`, the remaining 2 are granted.
- COOLDOWN_FRAMES=2: event on source 0 accepted, then hits on source 0 in the next 2 frames -> ignored, with no `pending` or `overrun` change. A hit in the third frame -> granted.
- Assert `reset` while `ev_valid`=1 and `ev_ready`=0 -> next cycle all outputs are 0, and pending hits are discarded.

Source files
------------

// File: rtl/hit_event_arbiter.sv
// rtl/hit_event_arbiter.sv - four-source hit event arbiter; HIT_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module hit_event_arbiter #(
    parameter int unsigned MAX_PER_FRAME   = 4,
    parameter int unsigned COOLDOWN_FRAMES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic [3:0] hit_pulse,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [1:0] ev_id,
    output logic [3:0] pending,
    output logic [3:0] overrun
);

    localparam logic [3:0] BUDGET_LOAD = 4'(MAX_PER_FRAME);
    localparam logic [3:0] CD_LOAD     = 4'(COOLDOWN_FRAMES);

    typedef enum logic {IDLE, PRESENT} state_t;

    state_t     state;
    logic [3:0] budget;
    logic [3:0] cooldown [4];
    logic [3:0] hit_acc;
    logic [3:0] grant_mask;
    logic [1:0] winner;
    logic       grant;
    logic       handshake;

`ifdef HIT_ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;

    // Winner is the first pending source after the last accepted one, wrapping
    always_comb begin
        logic [1:0] idx;
        logic       found;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= 4; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && pending[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end
`else
    // Winner is the lowest-index pending source
    always_comb begin
        winner = '0;
        for (int k = 3; k >= 0; k--) begin
            if (pending[k]) winner = 2'(k);
        end
    end
`endif

    // Hit filtering, grant decision and handshake detection
    always_comb begin
        hit_acc = '0;
        for (int i = 0; i < 4; i++) begin
            hit_acc[i] = hit_pulse[i] && (cooldown[i] == 4'd0);
        end
        grant      = (state == IDLE) && (pending != 4'd0) && (budget != 4'd0);
        grant_mask = grant ? (4'b0001 << winner) : 4'b0000;
        handshake  = (state == PRESENT) && ev_ready;
    end

    // Latch hits, run the present/accept FSM, track budget and cooldowns
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ev_valid <= 1'b0;
            ev_id    <= '0;
            pending  <= '0;
            overrun  <= '0;
            budget   <= BUDGET_LOAD;
            for (int i = 0; i < 4; i++) cooldown[i] <= '0;
`ifdef HIT_ARB_ROUND_ROBIN_EN
            rr_ptr   <= 2'd3;
`endif
        end else begin
            // A new accepted hit on the source being granted re-arms it without overrun
            pending <= (pending & ~grant_mask) | hit_acc;
            overrun <= overrun | (hit_acc & pending & ~grant_mask);

            case (state)
                IDLE: begin
                    if (grant) begin
                        ev_valid <= 1'b1;
                        ev_id    <= winner;
                        state    <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (ev_ready) begin
                        ev_valid <= 1'b0;
                        state    <= IDLE;
`ifdef HIT_ARB_ROUND_ROBIN_EN
                        rr_ptr   <= ev_id;
`endif
                    end
                end
                default: state <= IDLE;
            endcase

            // Frame reload beats a same-cycle decrement
            if (startOfFrame)   budget <= BUDGET_LOAD;
            else if (handshake) budget <= budget - 4'd1;

            // Cooldown load beats a same-cycle frame decrement
            for (int i = 0; i < 4; i++) begin
                if (handshake && (ev_id == 2'(i)))
                    cooldown[i] <= CD_LOAD;
                else if (startOfFrame && (cooldown[i] != 4'd0))
                    cooldown[i] <= cooldown[i] - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_hit_event_arbiter.sv
// tb/tb_hit_event_arbiter.sv - randomized and directed bench for hit_event_arbiter against a rule-level model
module tb_hit_event_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       sof;
    logic [3:0] hit;
    logic       ready;

    logic       valid_a, valid_b;
    logic [1:0] id_a, id_b;
    logic [3:0] pending_a, pending_b;
    logic [3:0] overrun_a, overrun_b;

    always #5 clk = ~clk;

    hit_event_arbiter u_dut_a (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .hit_pulse    (hit),
        .ev_ready     (ready),
        .ev_valid     (valid_a),
        .ev_id        (id_a),
        .pending      (pending_a),
        .overrun      (overrun_a)
    );

    hit_event_arbiter #(.MAX_PER_FRAME(2), .COOLDOWN_FRAMES(0)) u_dut_b (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (sof),
        .hit_pulse    (hit),
        .ev_ready     (ready),
        .ev_valid     (valid_b),
        .ev_id        (id_b),
        .pending      (pending_b),
        .overrun      (overrun_b)
    );

    typedef struct packed {
        logic            valid;
        logic [1:0]      id;
        logic [3:0]      pend;
        logic [3:0]      ovr;
        logic [4:0]      budget;
        logic [3:0][3:0] cd;
        logic [1:0]      rr;
    } model_t;

    model_t m_a, m_b;

    int n_checks = 0;
    int n_pass   = 0;

    int ids[$];
    int at[$];
    int cnt;
    int flen;
    logic [3:0] fired;
    logic [3:0] h;
    logic       s, r, rs;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    function automatic int pick(input logic [3:0] p, input logic [1:0] rr);
`ifdef HIT_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= 4; k++) begin
            if (p[(int'(rr) + k) % 4]) return (int'(rr) + k) % 4;
        end
`else
        for (int k = 0; k < 4; k++) begin
            if (p[k]) return k;
        end
`endif
        return 0;
    endfunction

    function automatic model_t step(input model_t st, input int maxb, input int cdl,
                                    input logic rst, input logic fr, input logic [3:0] hp,
                                    input logic rdy);
        model_t     n;
        logic [3:0] acc;
        logic [3:0] gm;
        logic       hs;
        int         w;
        n = st;
        if (rst) begin
            n = '0;
            n.budget = 5'(maxb);
            n.rr = 2'd3;
            return n;
        end
        hs  = st.valid && rdy;
        gm  = '0;
        acc = '0;
        for (int i = 0; i < 4; i++) acc[i] = hp[i] && (st.cd[i] == 4'd0);
        if (!st.valid) begin
            if (st.pend != 4'd0 && st.budget != 5'd0) begin
                w = pick(st.pend, st.rr);
                n.valid = 1'b1;
                n.id = 2'(w);
                gm[w] = 1'b1;
            end
        end else if (hs) begin
            n.valid = 1'b0;
            n.budget = st.budget - 5'd1;
            n.cd[st.id] = 4'(cdl);
            n.rr = st.id;
        end
        n.pend = (st.pend & ~gm) | acc;
        n.ovr  = st.ovr | (acc & st.pend & ~gm);
        if (fr) begin
            n.budget = 5'(maxb);
            for (int i = 0; i < 4; i++) begin
                if (!(hs && st.id == 2'(i)) && st.cd[i] != 4'd0) n.cd[i] = st.cd[i] - 4'd1;
            end
        end
        return n;
    endfunction

    task automatic compare_models();
        check("a_valid",   32'(valid_a),   32'(m_a.valid));
        check("a_id",      32'(id_a),      32'(m_a.id));
        check("a_pending", 32'(pending_a), 32'(m_a.pend));
        check("a_overrun", 32'(overrun_a), 32'(m_a.ovr));
        check("b_valid",   32'(valid_b),   32'(m_b.valid));
        check("b_id",      32'(id_b),      32'(m_b.id));
        check("b_pending", 32'(pending_b), 32'(m_b.pend));
        check("b_overrun", 32'(overrun_b), 32'(m_b.ovr));
    endtask

    task automatic tick(input logic rst, input logic fr, input logic [3:0] hp, input logic rdy);
        reset = rst;
        sof   = fr;
        hit   = hp;
        ready = rdy;
        @(posedge clk);
        m_a = step(m_a, 4, 2, rst, fr, hp, rdy);
        m_b = step(m_b, 2, 0, rst, fr, hp, rdy);
        @(negedge clk);
        compare_models();
    endtask

    task automatic collect(input int n);
        ids.delete();
        at.delete();
        for (int k = 1; k <= n; k++) begin
            tick(1'b0, 1'b0, 4'b0000, 1'b1);
            if (valid_a) begin
                ids.push_back(int'(id_a));
                at.push_back(k);
            end
        end
    endtask

    task automatic check_seq_013(input string tag);
        check({tag, "_count"}, 32'(ids.size()), 32'd3);
        if (ids.size() == 3) begin
            check({tag, "_id0"}, 32'(ids[0]), 32'd0);
            check({tag, "_id1"}, 32'(ids[1]), 32'd1);
            check({tag, "_id2"}, 32'(ids[2]), 32'd3);
            check({tag, "_t0"},  32'(at[0]),  32'd1);
            check({tag, "_t1"},  32'(at[1]),  32'd3);
            check({tag, "_t2"},  32'(at[2]),  32'd5);
        end
    endtask

    initial begin
        m_a = '0;
        m_b = '0;

        // Reset values
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        check("rst_valid",   32'(valid_a),   32'd0);
        check("rst_id",      32'(id_a),      32'd0);
        check("rst_pending", 32'(pending_a), 32'd0);
        check("rst_overrun", 32'(overrun_a), 32'd0);

        // Single hit latency and one-cycle valid with ready high
        repeat (7) tick(1'b0, 1'b0, 4'b0000, 1'b1);
        tick(1'b0, 1'b0, 4'b0100, 1'b1);
        check("t1_pending", 32'(pending_a), 32'h4);
        check("t1_early",   32'(valid_a),   32'd0);
        tick(1'b0, 1'b0, 4'b0000, 1'b1);
        check("t1_valid",   32'(valid_a),   32'd1);
        check("t1_id",      32'(id_a),      32'd2);
        tick(1'b0, 1'b0, 4'b0000, 1'b1);
        check("t1_drop",    32'(valid_a),   32'd0);

        // Three-source burst, then again after cooldowns expire
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        tick(1'b0, 1'b1, 4'b0000, 1'b1);
        tick(1'b0, 1'b0, 4'b1011, 1'b1);
        collect(8);
        check_seq_013("t2a");
        repeat (3) begin
            tick(1'b0, 1'b1, 4'b0000, 1'b1);
            repeat (4) tick(1'b0, 1'b0, 4'b0000, 1'b1);
        end
        tick(1'b0, 1'b0, 4'b1011, 1'b1);
        collect(8);
        check_seq_013("t2b");

        // Long stall on source 1 with re-hit and overrun
        tick(1'b1, 1'b0, 4'b0000, 1'b0);
        tick(1'b0, 1'b1, 4'b0000, 1'b0);
        tick(1'b0, 1'b0, 4'b0010, 1'b0);
        tick(1'b0, 1'b0, 4'b0000, 1'b0);
        check("t3_valid", 32'(valid_a), 32'd1);
        check("t3_id",    32'(id_a),    32'd1);
        for (int k = 0; k < 20; k++) begin
            if (k == 4 || k == 10)      tick(1'b0, 1'b1, 4'b0000, 1'b0);
            else if (k == 6 || k == 12) tick(1'b0, 1'b0, 4'b0010, 1'b0);
            else                        tick(1'b0, 1'b0, 4'b0000, 1'b0);
            check("t3_hold_valid", 32'(valid_a), 32'd1);
            check("t3_hold_id",    32'(id_a),    32'd1);
        end
        check("t3_pending", 32'(pending_a), 32'h2);
        check("t3_overrun", 32'(overrun_a), 32'h2);
        repeat (4) tick(1'b0, 1'b0, 4'b0000, 1'b1);

        // Budget of 2 per frame on the second instance
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        tick(1'b0, 1'b1, 4'b0000, 1'b1);
        tick(1'b0, 1'b0, 4'b1111, 1'b1);
        cnt = 0;
        repeat (10) begin
            tick(1'b0, 1'b0, 4'b0000, 1'b1);
            if (valid_b) cnt++;
        end
        check("t4_events_f1",  32'(cnt),       32'd2);
        check("t4_pending_f1", 32'(pending_b), 32'hC);
        cnt = 0;
        tick(1'b0, 1'b1, 4'b0000, 1'b1);
        if (valid_b) cnt++;
        repeat (10) begin
            tick(1'b0, 1'b0, 4'b0000, 1'b1);
            if (valid_b) cnt++;
        end
        check("t4_events_f2",  32'(cnt),       32'd2);
        check("t4_pending_f2", 32'(pending_b), 32'h0);

        // Cooldown of 2 frames on the default instance
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        tick(1'b0, 1'b1, 4'b0000, 1'b1);
        tick(1'b0, 1'b0, 4'b0001, 1'b1);
        repeat (4) tick(1'b0, 1'b0, 4'b0000, 1'b1);
        repeat (2) begin
            tick(1'b0, 1'b1, 4'b0001, 1'b1);
            check("t5_drop_pending", 32'(pending_a), 32'h0);
            check("t5_drop_overrun", 32'(overrun_a), 32'h0);
            repeat (4) tick(1'b0, 1'b0, 4'b0000, 1'b1);
        end
        tick(1'b0, 1'b1, 4'b0001, 1'b1);
        check("t5_accept", 32'(pending_a), 32'h1);
        tick(1'b0, 1'b0, 4'b0000, 1'b1);
        check("t5_valid", 32'(valid_a), 32'd1);
        check("t5_id",    32'(id_a),    32'd0);
        tick(1'b0, 1'b0, 4'b0000, 1'b1);

        // Reset while presenting with ready low
        tick(1'b0, 1'b1, 4'b0000, 1'b0);
        tick(1'b0, 1'b0, 4'b0110, 1'b0);
        tick(1'b0, 1'b0, 4'b0000, 1'b0);
        check("t6_presenting", 32'(valid_a), 32'd1);
        tick(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t6_valid",   32'(valid_a),   32'd0);
        check("t6_id",      32'(id_a),      32'd0);
        check("t6_pending", 32'(pending_a), 32'h0);
        check("t6_overrun", 32'(overrun_a), 32'h0);
        repeat (3) begin
            tick(1'b0, 1'b0, 4'b0000, 1'b1);
            check("t6_lost", 32'(valid_a), 32'd0);
        end

        // Randomized traffic against the model
        tick(1'b1, 1'b0, 4'b0000, 1'b1);
        flen  = 0;
        fired = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            s = (flen == 0);
            if (s) begin
                flen  = $urandom_range(6, 20);
                fired = '0;
            end
            flen--;
            h = '0;
            if ($urandom_range(0, 3) == 0) h = 4'($urandom) & ~fired;
            fired = fired | h;
            r  = ($urandom_range(0, 3) != 0);
            rs = ($urandom_range(0, 999) == 0);
            tick(rs, s, h, r);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
